// File: rtl/present_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : present_decrypt_ctrl (+ SBoxEncrypt, SBoxDecrypt,
//                SubsLayerDecryption leaves)
//  Description : Iterative PRESENT-80 decryption controller. Runs the forward
//                key schedule up to the last round key, whitens, then walks
//                the inverse rounds back down to round 1.
//  Revision    : 1.0 - initial release
// ============================================================================

// PRESENT 4-bit S-box (forward direction, used by the key schedule)
module SBoxEncrypt (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    // Forward S-box lookup
    always_comb begin
        o_nib = 4'h0;
        case (i_nib)
            4'h0: o_nib = 4'hC;
            4'h1: o_nib = 4'h5;
            4'h2: o_nib = 4'h6;
            4'h3: o_nib = 4'hB;
            4'h4: o_nib = 4'h9;
            4'h5: o_nib = 4'h0;
            4'h6: o_nib = 4'hA;
            4'h7: o_nib = 4'hD;
            4'h8: o_nib = 4'h3;
            4'h9: o_nib = 4'hE;
            4'hA: o_nib = 4'hF;
            4'hB: o_nib = 4'h8;
            4'hC: o_nib = 4'h4;
            4'hD: o_nib = 4'h7;
            4'hE: o_nib = 4'h1;
            default: o_nib = 4'h2;
        endcase
    end
endmodule

// PRESENT 4-bit inverse S-box
module SBoxDecrypt (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    // Inverse S-box lookup
    always_comb begin
        o_nib = 4'h0;
        case (i_nib)
            4'h0: o_nib = 4'h5;
            4'h1: o_nib = 4'hE;
            4'h2: o_nib = 4'hF;
            4'h3: o_nib = 4'h8;
            4'h4: o_nib = 4'hC;
            4'h5: o_nib = 4'h1;
            4'h6: o_nib = 4'h2;
            4'h7: o_nib = 4'hD;
            4'h8: o_nib = 4'hB;
            4'h9: o_nib = 4'h4;
            4'hA: o_nib = 4'h6;
            4'hB: o_nib = 4'h3;
            4'hC: o_nib = 4'h0;
            4'hD: o_nib = 4'h7;
            4'hE: o_nib = 4'h9;
            default: o_nib = 4'hA;
        endcase
    end
endmodule

// Inverse substitution layer: 16 parallel inverse S-boxes over 64 bits
module SubsLayerDecryption (
    input  logic [63:0] i_data,
    output logic [63:0] o_data
);
    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_nib
            SBoxDecrypt u_sbox (
                .i_nib (i_data[4*g +: 4]),
                .o_nib (o_data[4*g +: 4])
            );
        end
    endgenerate
endmodule

module present_decrypt_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [4:0]  round_cnt
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_keygen = 3'd1;
    localparam logic [2:0] c_st_whiten = 3'd2;
    localparam logic [2:0] c_st_round  = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [4:0] c_last_rc   = 5'(ROUNDS);

    logic [2:0]  r_state;
    logic [63:0] r_st;
    logic [79:0] r_kr;
    logic [4:0]  r_rc;

    // Forward key update: rotate left 61, S-box on top nibble, add counter
    logic [79:0] w_rot_fwd;
    logic [3:0]  w_fwd_nib;
    logic [79:0] w_key_fwd;

    assign w_rot_fwd = {r_kr[18:0], r_kr[79:19]};

    SBoxEncrypt u_key_sbox (
        .i_nib (w_rot_fwd[79:76]),
        .o_nib (w_fwd_nib)
    );

    assign w_key_fwd = {w_fwd_nib, w_rot_fwd[75:20],
                        w_rot_fwd[19:15] ^ r_rc, w_rot_fwd[14:0]};

    // Inverse key update: remove counter, inverse S-box, rotate right 61
    logic [79:0] w_kx;
    logic [3:0]  w_inv_nib;
    logic [79:0] w_ky;
    logic [79:0] w_key_inv;

    assign w_kx = {r_kr[79:20], r_kr[19:15] ^ r_rc, r_kr[14:0]};

    SBoxDecrypt u_key_isbox (
        .i_nib (w_kx[79:76]),
        .o_nib (w_inv_nib)
    );

    assign w_ky      = {w_inv_nib, w_kx[75:0]};
    assign w_key_inv = {w_ky[60:0], w_ky[79:61]};

    // Inverse bit permutation: bit i takes input bit 16*i mod 63, bit 63 fixed
    logic [63:0] w_perm;

    genvar gi;
    generate
        for (gi = 0; gi < 63; gi++) begin : g_invp
            assign w_perm[gi] = r_st[(16 * gi) % 63];
        end
    endgenerate
    assign w_perm[63] = r_st[63];

    logic [63:0] w_sub;

    SubsLayerDecryption u_subs (
        .i_data (w_perm),
        .o_data (w_sub)
    );

    // Control FSM plus state, key and round-counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_st    <= 64'd0;
            r_kr    <= 80'd0;
            r_rc    <= 5'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_st    <= in_data;
                        r_kr    <= in_key;
                        r_rc    <= 5'd1;
                        r_state <= c_st_keygen;
                    end
                end
                c_st_keygen: begin
                    r_kr <= w_key_fwd;
                    if (r_rc == c_last_rc) begin
                        // Hold the counter rather than stepping past ROUNDS
                        r_state <= c_st_whiten;
                    end else begin
                        r_rc <= r_rc + 5'd1;
                    end
                end
                c_st_whiten: begin
                    r_st    <= r_st ^ r_kr[79:16];
                    r_rc    <= c_last_rc;
                    r_state <= c_st_round;
                end
                c_st_round: begin
                    r_st <= w_sub ^ w_key_inv[79:16];
                    r_kr <= w_key_inv;
                    r_rc <= r_rc - 5'd1;
                    if (r_rc == 5'd1) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign out_data  = r_st;
    assign round_cnt = r_rc;

endmodule
`default_nettype wire

// File: tb/tb_present_decrypt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_present_decrypt_ctrl
//  Description : Self-checking bench for the PRESENT-80 decryption controller.
//                Known-answer vectors, handshake corner cases, async reset
//                abort and random jobs against a reference encryptor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_present_decrypt_ctrl;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [79:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic [4:0]  round_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] ct;
        logic [79:0] key;
        logic [63:0] pt;
        int          hold;
        bit          tied;
        bit          junk;
    } vec_t;

    vec_t vecs[4];

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_decrypt_ctrl #(.ROUNDS(31)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_cnt (round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PRESENT-80 encryption written straight from the cipher rules
    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [79:0] k;
        logic [63:0] s;
        logic [63:0] t;
        k = key;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 63; i++) t[(16 * i) % 63] = s[i];
            t[63] = s[63];
            s = t;
            k = (k << 61) | (k >> 19);
            k[79:76] = SB[k[79:76]];
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One full job; called and returns at a falling edge
    task automatic run_job(input logic [63:0] ct, input logic [79:0] key, input logic [63:0] exp,
                           input int hold, input bit tied, input bit junk);
        int n;
        in_valid  = 1'b1;
        in_data   = ct;
        in_key    = key;
        out_ready = tied;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", {62'd0, busy, in_ready}, 64'b10);
        n = 0;
        while (!out_valid && n < 200) begin
            if (junk) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom(), $urandom()};
                in_key   = {16'($urandom()), $urandom(), $urandom()};
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("latency", 64'(n), 64'd63);
        check("result", out_data, exp);
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        if (tied) begin
            @(negedge clk);
            check("one_cycle_valid", {62'd0, out_valid, in_ready}, 64'b01);
        end else begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("hold_stable", {61'd0, out_valid, in_ready, out_data == exp}, 64'b101);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("handback_idle", {62'd0, out_valid, in_ready}, 64'b01);
            out_ready = 1'b0;
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pt;
        logic [63:0] ct;
        logic [79:0] key;
        int          n;

        vecs[0] = '{64'h5579C1387B228445, 80'h0,                    64'h0,                 10, 1'b0, 1'b0};
        vecs[1] = '{64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF, 64'h0,                 0,  1'b0, 1'b1};
        vecs[2] = '{64'hA112FFC72F68417B, 80'h0,                    64'hFFFFFFFFFFFFFFFF,  0,  1'b1, 1'b0};
        vecs[3] = '{64'h3333DCD3213210D2, 80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,  0,  1'b1, 1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_state", {in_ready, out_valid, busy, round_cnt, 55'd0},
              {1'b1, 1'b0, 1'b0, 5'd0, 55'd0});
        check("reset_out_data", out_data, 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_job(vecs[v].ct, vecs[v].key, vecs[v].pt, vecs[v].hold, vecs[v].tied, vecs[v].junk);
        end

        // Asynchronous reset abort in the middle of a job
        in_valid = 1'b1;
        in_data  = vecs[0].ct;
        in_key   = vecs[0].key;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (round_cnt != 5'd17 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_rc17", 64'(round_cnt), 64'd17);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", {59'd0, in_ready, out_valid, busy, round_cnt == 5'd0, 1'b0},
              {59'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        check("async_reset_data", out_data, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("no_output_after_abort", 64'(out_valid), 64'd0);
        run_job(vecs[1].ct, vecs[1].key, vecs[1].pt, 2, 1'b0, 1'b0);

        // Random jobs against the reference encryptor
        for (int r = 0; r < 4; r++) begin
            pt  = {$urandom(), $urandom()};
            key = {16'($urandom()), $urandom(), $urandom()};
            ct  = ref_encrypt(pt, key);
            run_job(ct, key, pt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/present_decrypt_ctrl.md
Name: present_decrypt_ctrl

Overview:
- Iterative PRESENT-80 decryption engine controller.
- Accepts a 64-bit ciphertext and an 80-bit user key over a valid/ready handshake.
- Runs the forward key schedule to recover the final round key, then sequences 31 inverse rounds through one shared SubsLayerDecryption instance, an internal inverse permutation and the inverse key schedule.
- Returns the plaintext over a valid/ready handshake. Sits between the host interface and the decryption datapath.

Parameters:
- ROUNDS, 31, number of PRESENT rounds. All test vectors assume 31.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ciphertext/key offer.
- in_ready  output  1  block can accept a new job.
- in_data  input  `size (64)  ciphertext.
- in_key  input  80  user key K, bit 79 MSB.
- out_valid  output  1  plaintext available.
- out_ready  input  1  consumer accepts plaintext.
- out_data  output  `size (64)  plaintext.
- busy  output  1  high in any state other than IDLE.
- round_cnt  output  5  current round counter (debug).

Behaviour:
- Reset is asynchronous and active-low. Reset drives: state IDLE; in_ready=1; out_valid=0; busy=0; out_data=0; round_cnt=0; key and data registers 0.
- Reset asserted mid-operation aborts the job immediately. No output is produced for the aborted job.
- Registers: st[63:0], kr[79:0], rc[4:0]. out_data=st at all times, but it is only meaningful while out_valid=1.
- Forward key update, using rc:
  - Rotate kr left 61.
  - Apply the S-box to [79:76] via the SBoxEncrypt leaf.
  - XOR rc into [19:15].
- Inverse key update, using rc:
  - XOR rc into [19:15].
  - Apply the inverse S-box to [79:76] via the SBoxDecrypt leaf.
  - Rotate right 61.
- Inverse permutation: output bit i = input bit P(i), where P(i)=16*i mod 63 for i<63 and P(63)=63.
- FSM states:
  - IDLE:
    - in_ready=1.
    - When in_valid&&in_ready: st<=in_data, kr<=in_key, rc<=1, go to KEYGEN.
  - KEYGEN:
    - Each cycle: kr<=fwd(kr,rc), rc<=rc+1.
    - Moves to WHITEN on the edge where the update with rc==ROUNDS is performed. kr then holds K32.
  - WHITEN:
    - One cycle: st<=st^kr[79:16], rc<=ROUNDS, go to ROUND.
  - ROUND:
    - Let nk=inv(kr,rc).
    - Each cycle: st<=SubsLayerDecryption(invP(st))^nk[79:16], kr<=nk, rc<=rc-1.
    - After the edge performing rc==1, go to DONE.
  - DONE:
    - out_valid=1, with st and out_data held stable.
    - When out_ready: out_valid<=0, go to IDLE.
- Latency: out_valid rises 63 rising edges after the accepting edge (31 KEYGEN + 1 WHITEN + 31 ROUND).
- Throughput: next accept occurs at the earliest on the edge after IDLE is re-entered. There is no overlap; in_ready=0 outside IDLE.
- in_data and in_key are sampled only on the accept edge; later changes are ignored.
- in_valid while busy is ignored; the requester holds its request until in_ready.
- out_ready while out_valid=0 is ignored.
- out_ready already high when DONE is entered: out_valid is high for exactly one cycle.
- rc never wraps. Values outside 1..ROUNDS are unreachable; an implementation must not rely on wrap.

Test Plan:
- Key 0, ct 5579C1387B228445 -> out_data 0000000000000000. out_valid rises exactly 63 edges after accept.
- Key FFFFFFFFFFFFFFFFFFFF, ct E72C46C0F5945049 -> pt 0000000000000000.
- Key 0, ct A112FFC72F68417B -> FFFFFFFFFFFFFFFF. Then key all-F, ct 3333DCD3213210D2 -> FFFFFFFFFFFFFFFF, back-to-back with out_ready tied 1.
- out_ready held low 10 cycles after out_valid -> out_valid and out_data stable all 10 cycles; in_ready=0 throughout. Accept occurs on the first edge with out_ready=1; IDLE follows.
- in_valid pulsed and in_data/in_key changed during KEYGEN and ROUND -> no effect; result matches the original job.
- reset_n low asynchronously at round_cnt=17 -> outputs take reset values before the next edge. Fresh job after release decrypts correctly.
